nested_break_seq: RTL
=====================

Name: nested_break_seq

Overview:
- Run-time sequential engine for a two-level nested loop with early `break` at both levels.
- Loop bounds, break points and step value are latched at start; the loop body executes one inner iteration per clock.
- Accumulates results into `a` and `b`, then signals completion.
- Serves as the clocked counterpart to the constant-folded nested-break tests, and is used to cross-check elaborated loop semantics against hardware execution.

Parameters:
- OUTER_MAX, 10, outer loop bound; `i` runs 0..OUTER_MAX-1.
- INNER_MAX, 10, inner loop bound; `j` runs 0..INNER_MAX-1.
- W, 32, width of accumulators and of `step_a`.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  start request, sampled in IDLE or DONE.
- step_a  input  W  base increment for `a`, latched on accepted start.
- brk_outer  input  8  outer break index, latched on accepted start.
- brk_inner  input  8  inner break index, latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results become final.
- a  output  W  accumulator A.
- b  output  W  accumulator B, which counts executed body iterations.

Behaviour:
- Reset (rst_n low at a clock edge): state goes to IDLE. `a`=0, `b`=0, `busy`=0, `done`=0, and internal `i`/`j` are cleared. Reset overrides everything, including mid-RUN; a run in progress is abandoned and no `done` is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - latch `step_a`, `brk_outer`, `brk_inner`;
  - clear `a`, `b`, `i`, `j`;
  - go to RUN.
- RUN, each cycle executes one body iteration:
  - `a <= a + step_a_l + i`, where `i` is zero-extended to W;
  - `b <= b + 1`;
  - all arithmetic is modulo 2^W (wraps, no saturation).
- Break and advance rules in RUN, evaluated after the body in the same cycle (C semantics: body, then `if (j==brk_inner) break`):
  - inner_end = (j == brk_inner) or (j == INNER_MAX-1);
  - outer_end = (i == brk_outer) or (i == OUTER_MAX-1);
  - if !inner_end: j <= j+1;
  - else if !outer_end: j <= 0, i <= i+1;
  - else: go to DONE.
- Iteration count: executed iterations = min(brk_outer+1, OUTER_MAX) × min(brk_inner+1, INNER_MAX). A break index at or above its bound means no break (full loop).
- Latency: `busy` rises the cycle after start is accepted and stays high for exactly N cycles (N = iteration count). `done` is high for exactly the one cycle when the state is DONE.
- `a` and `b` update every RUN cycle and are final when `done`=1. They hold their values in DONE and in the following IDLE until the next accepted start.
- start while in RUN is ignored, and inputs are not re-latched.
- start in the DONE cycle is accepted. The next state is RUN, `done` is still high that cycle, and accumulators clear on the following edge.
- Inputs other than start are don't-care outside the accepting cycle.

Test Plan:
1. step_a=4, brk_outer=3, brk_inner=4, one-cycle start -> `busy` high 20 cycles, single `done` pulse, a=110, b=20.
2. brk_outer=200, brk_inner=200, step_a=1 -> 100 iterations, a=100+10×45=550, b=100, `busy` high 100 cycles.
3. brk_outer=0, brk_inner=0, step_a=7 -> 1 iteration, a=7, b=1; `done` two cycles after start is accepted.
4. Pulse start again at cycles 2 and 5 of test 1's run -> ignored; results still a=110, b=20, one `done`.
5. Assert rst_n low at RUN cycle 10 of test 1 -> next edge gives a=0, b=0, `busy`=0; no `done`. A fresh start then reproduces a=110, b=20.
6. step_a=2^W-1, brk_outer=0, brk_inner=1 -> wraparound: a=2^W-2, b=2. Start asserted in the DONE cycle -> new run begins immediately with cleared accumulators.

Source files
------------

// File: rtl/nested_break_seq.sv
// rtl/nested_break_seq.sv - clocked two-level nested loop with early break at both levels
module nested_break_seq #(
    parameter int OUTER_MAX = 10,
    parameter int INNER_MAX = 10,
    parameter int W         = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] step_a,
    input  logic [7:0]   brk_outer,
    input  logic [7:0]   brk_inner,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] a,
    output logic [W-1:0] b
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] I_LAST = 8'(OUTER_MAX - 1);
    localparam logic [7:0] J_LAST = 8'(INNER_MAX - 1);

    state_t       state;
    logic [W-1:0] step_a_l;
    logic [7:0]   brk_outer_l;
    logic [7:0]   brk_inner_l;
    logic [7:0]   i;
    logic [7:0]   j;
    logic         inner_end;
    logic         outer_end;

    // Break tests see the indices of the iteration whose body runs this cycle.
    assign inner_end = (j == brk_inner_l) || (j == J_LAST);
    assign outer_end = (i == brk_outer_l) || (i == I_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            step_a_l    <= '0;
            brk_outer_l <= '0;
            brk_inner_l <= '0;
            i           <= '0;
            j           <= '0;
            a           <= '0;
            b           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        step_a_l    <= step_a;
                        brk_outer_l <= brk_outer;
                        brk_inner_l <= brk_inner;
                        a           <= '0;
                        b           <= '0;
                        i           <= '0;
                        j           <= '0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a <= a + step_a_l + W'(i);
                    b <= b + 1'b1;
                    if (!inner_end) begin
                        j <= j + 1'b1;
                    end else if (!outer_end) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
